// File: rtl/pcie_axi_sram_pkg.sv
// Shared constants, FSM encoding and word-index stepping for the AXI-to-SRAM read pipe.
package pcie_axi_sram_pkg;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;
  localparam logic [1:0] BURST_RSVD  = 2'b11;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BURST = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  // WRAP keeps the bits above the window fixed and increments only inside it.
  function automatic logic [31:0] next_word_idx(input logic [31:0] idx,
                                                input logic [1:0]  burst,
                                                input logic [31:0] wrap_mask);
    case (burst)
      BURST_FIXED: next_word_idx = idx;
      BURST_WRAP:  next_word_idx = (idx & ~wrap_mask) | ((idx + 32'd1) & wrap_mask);
      default:     next_word_idx = idx + 32'd1;
    endcase
  endfunction

endpackage

// File: rtl/pcie_axi_sram_rd_fifo.sv
// Small read-data FIFO; head reads as zero while empty so R payload is clean when idle.
module pcie_axi_sram_rd_fifo #(
  parameter int WIDTH = 259,
  parameter int DEPTH = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             empty
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    count;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    ptr_inc = (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  assign empty = (count == '0);
  assign head  = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/pcie_axi_sram_rd_pipe.sv
// AXI read slave over a fixed-latency SRAM: one burst at a time, credit-limited issue into a FIFO.
// Handshakes: a transfer happens on a rising edge where valid and ready are both high; valid never waits on ready.
module pcie_axi_sram_rd_pipe
  import pcie_axi_sram_pkg::*;
#(
  parameter int DATA_W  = 256,
  parameter int ADDR_W  = 64,
  parameter int SRAM_AW = 10,
  parameter int LEN_W   = 12,
  parameter int RD_LAT  = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               axi_arvalid,
  output logic               axi_arready,
  input  logic [ADDR_W-1:0]  axi_araddr,
  input  logic [LEN_W-1:0]   axi_arlen,
  input  logic [2:0]         axi_arsize,
  input  logic [1:0]         axi_arburst,
  output logic               axi_rvalid,
  input  logic               axi_rready,
  output logic [DATA_W-1:0]  axi_rdata,
  output logic [1:0]         axi_rresp,
  output logic               axi_rlast,
  output logic               sram_ren,
  output logic [SRAM_AW-1:0] sram_raddr,
  input  logic [DATA_W-1:0]  sram_rdata,
  output logic [1:0]         dbg_state
);
  localparam int OFS     = $clog2(DATA_W / 8);
  localparam int CREDITS = RD_LAT + 2;
  localparam int CNT_W   = $clog2(CREDITS + 1);
  localparam int FW      = DATA_W + 3;

  state_t              state, state_nxt;
  logic                init_done, ar_hs, issue, pop, ar_err, fifo_empty;
  logic [SRAM_AW-1:0]  word_idx, wrap_mask, ar_idx;
  logic [1:0]          burst_q;
  logic                err_q;
  logic [LEN_W:0]      issue_left, ar_beats;
  logic [CNT_W-1:0]    outstanding;
  logic [32:0]         incr_end;
  logic [RD_LAT-1:0]   pipe_vld, pipe_err, pipe_last;
  logic [FW-1:0]       fifo_in, fifo_head;
  logic                unused_lsbs;

  assign unused_lsbs = ^axi_araddr[OFS-1:0];

  // Request decode and error screening on the raw AR payload.
  always_comb begin
    ar_beats = {1'b0, axi_arlen} + (LEN_W + 1)'(1);
    ar_idx   = axi_araddr[OFS +: SRAM_AW];
    incr_end = 33'(ar_idx) + 33'(ar_beats);
    ar_err   = 1'b0;
    if ((axi_araddr >> (OFS + SRAM_AW)) != '0) ar_err = 1'b1;
    if (axi_arsize != 3'(OFS))                 ar_err = 1'b1;
    if (axi_arburst == BURST_RSVD)             ar_err = 1'b1;
    if (axi_arburst == BURST_INCR && incr_end > (33'd1 << SRAM_AW)) ar_err = 1'b1;
    if (axi_arburst == BURST_WRAP &&
        !(ar_beats == (LEN_W + 1)'(2) || ar_beats == (LEN_W + 1)'(4) ||
          ar_beats == (LEN_W + 1)'(8) || ar_beats == (LEN_W + 1)'(16))) ar_err = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (ar_hs) state_nxt = ST_BURST;
      ST_BURST: if (issue && issue_left == (LEN_W + 1)'(1)) state_nxt = ST_DRAIN;
      ST_DRAIN: if (pop && axi_rlast) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    axi_arready = 1'b0;
    issue       = 1'b0;
    case (state)
      ST_IDLE:  axi_arready = init_done;
      ST_BURST: issue = (outstanding < CNT_W'(CREDITS));
      default:  ;
    endcase
  end

  assign ar_hs      = axi_arvalid && axi_arready;
  assign pop        = axi_rvalid && axi_rready;
  assign sram_ren   = issue && !err_q;
  assign sram_raddr = word_idx;
  assign dbg_state  = state;

  // Outstanding counts beats issued but not yet popped, so the FIFO can never overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      init_done   <= 1'b0;
      word_idx    <= '0;
      wrap_mask   <= '0;
      burst_q     <= '0;
      err_q       <= 1'b0;
      issue_left  <= '0;
      outstanding <= '0;
      pipe_vld    <= '0;
      pipe_err    <= '0;
      pipe_last   <= '0;
    end else begin
      init_done <= 1'b1;
      if (ar_hs) begin
        word_idx   <= ar_idx;
        wrap_mask  <= SRAM_AW'(ar_beats - (LEN_W + 1)'(1));
        burst_q    <= axi_arburst;
        err_q      <= ar_err;
        issue_left <= ar_beats;
      end else if (issue) begin
        word_idx   <= SRAM_AW'(next_word_idx(32'(word_idx), burst_q, 32'(wrap_mask)));
        issue_left <= issue_left - (LEN_W + 1)'(1);
      end
      case ({issue, pop})
        2'b10:   outstanding <= outstanding + CNT_W'(1);
        2'b01:   outstanding <= outstanding - CNT_W'(1);
        default: outstanding <= outstanding;
      endcase
      pipe_vld[0]  <= issue;
      pipe_err[0]  <= err_q;
      pipe_last[0] <= (issue_left == (LEN_W + 1)'(1));
      for (int i = 1; i < RD_LAT; i++) begin
        pipe_vld[i]  <= pipe_vld[i-1];
        pipe_err[i]  <= pipe_err[i-1];
        pipe_last[i] <= pipe_last[i-1];
      end
    end
  end

  assign fifo_in = pipe_err[RD_LAT-1] ? {RESP_SLVERR, pipe_last[RD_LAT-1], {DATA_W{1'b0}}}
                                      : {RESP_OKAY, pipe_last[RD_LAT-1], sram_rdata};

  pcie_axi_sram_rd_fifo #(
    .WIDTH (FW),
    .DEPTH (CREDITS)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (pipe_vld[RD_LAT-1]),
    .push_data (fifo_in),
    .pop       (pop),
    .head      (fifo_head),
    .empty     (fifo_empty)
  );

  assign axi_rvalid = !fifo_empty;
  assign axi_rdata  = fifo_head[DATA_W-1:0];
  assign axi_rlast  = fifo_head[DATA_W];
  assign axi_rresp  = fifo_head[DATA_W+2:DATA_W+1];

endmodule

// File: tb/tb_pcie_axi_sram_rd_pipe.sv
// Bench for pcie_axi_sram_rd_pipe: SRAM model, R/SRAM monitors, burst-level reference model.
module tb_pcie_axi_sram_rd_pipe;
  localparam int DATA_W  = 256;
  localparam int ADDR_W  = 64;
  localparam int SRAM_AW = 10;
  localparam int LEN_W   = 12;
  localparam int RD_LAT  = 1;
  localparam int OFS     = 5;
  localparam int DEPTH   = 1 << SRAM_AW;
  localparam int BW      = DATA_W + 3;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               axi_arvalid = 1'b0, axi_arready;
  logic [ADDR_W-1:0]  axi_araddr = '0;
  logic [LEN_W-1:0]   axi_arlen = '0;
  logic [2:0]         axi_arsize = '0;
  logic [1:0]         axi_arburst = '0;
  logic               axi_rvalid, axi_rready = 1'b0;
  logic [DATA_W-1:0]  axi_rdata;
  logic [1:0]         axi_rresp;
  logic               axi_rlast;
  logic               sram_ren;
  logic [SRAM_AW-1:0] sram_raddr;
  logic [DATA_W-1:0]  sram_rdata;
  logic [1:0]         dbg_state;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  pcie_axi_sram_rd_pipe #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .SRAM_AW(SRAM_AW), .LEN_W(LEN_W), .RD_LAT(RD_LAT)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .axi_arvalid(axi_arvalid), .axi_arready(axi_arready), .axi_araddr(axi_araddr),
    .axi_arlen(axi_arlen), .axi_arsize(axi_arsize), .axi_arburst(axi_arburst),
    .axi_rvalid(axi_rvalid), .axi_rready(axi_rready), .axi_rdata(axi_rdata),
    .axi_rresp(axi_rresp), .axi_rlast(axi_rlast),
    .sram_ren(sram_ren), .sram_raddr(sram_raddr), .sram_rdata(sram_rdata),
    .dbg_state(dbg_state)
  );

  // Clock / reset block
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // SRAM model with RD_LAT cycles of read latency
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] sram_pipe [RD_LAT];
  always @(posedge clk) begin
    if (sram_ren) sram_pipe[0] <= mem[sram_raddr];
    for (int i = 1; i < RD_LAT; i++) sram_pipe[i] <= sram_pipe[i-1];
  end
  assign sram_rdata = sram_pipe[RD_LAT-1];

  // Monitors: record SRAM reads and R handshakes, count stall-stability violations
  logic [BW-1:0] obs_q[$];
  int            obs_cyc_q[$];
  int            addr_q[$];
  int            addr_cyc_q[$];
  int            stall_viol = 0;
  logic          prev_stall = 1'b0;
  logic [BW-1:0] prev_beat = '0;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall && (!axi_rvalid || {axi_rdata, axi_rresp, axi_rlast} !== prev_beat))
        stall_viol++;
      if (sram_ren) begin
        addr_q.push_back(int'(sram_raddr));
        addr_cyc_q.push_back(cyc);
      end
      if (axi_rvalid && axi_rready) begin
        obs_q.push_back({axi_rdata, axi_rresp, axi_rlast});
        obs_cyc_q.push_back(cyc);
      end
      prev_stall = axi_rvalid && !axi_rready;
      prev_beat  = {axi_rdata, axi_rresp, axi_rlast};
    end
  end

  // Reference model: expected beats and SRAM word sequence for one burst
  logic [BW-1:0] exp_q[$];
  int            exp_idx_q[$];
  function automatic void model_burst(input logic [ADDR_W-1:0] addr, input int len,
                                      input int size, input logic [1:0] burst);
    int n = len + 1;
    int start = int'(addr[OFS+SRAM_AW-1:OFS]);
    bit err = ((addr >> (OFS + SRAM_AW)) != 0) || (size != OFS) || (burst == 2'b11);
    if (burst == 2'b01 && start + n > DEPTH) err = 1'b1;
    if (burst == 2'b10 && !(n == 2 || n == 4 || n == 8 || n == 16)) err = 1'b1;
    exp_q.delete();
    exp_idx_q.delete();
    for (int i = 0; i < n; i++) begin
      int idx;
      if (burst == 2'b00)      idx = start;
      else if (burst == 2'b10) idx = (start / n) * n + (start % n + i) % n;
      else                     idx = start + i;
      if (err) exp_q.push_back({{DATA_W{1'b0}}, 2'b10, (i == n - 1)});
      else begin
        exp_q.push_back({mem[idx], 2'b00, (i == n - 1)});
        exp_idx_q.push_back(idx);
      end
    end
  endfunction

  // Driver tasks
  task automatic send_ar(input logic [ADDR_W-1:0] addr, input int len, input int size,
                         input logic [1:0] burst, output int hs_cyc, output bit to);
    @(posedge clk); #1;
    model_burst(addr, len, size, burst);
    obs_q.delete(); obs_cyc_q.delete(); addr_q.delete(); addr_cyc_q.delete();
    stall_viol  = 0;
    axi_araddr  = addr;
    axi_arlen   = LEN_W'(len);
    axi_arsize  = 3'(size);
    axi_arburst = burst;
    axi_arvalid = 1'b1;
    to = 1'b1;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (axi_arready) begin to = 1'b0; break; end
    end
    @(posedge clk); #1;
    hs_cyc = cyc;
    axi_arvalid = 1'b0;
  endtask

  // mode 0: rready high, 1: random, 2: 1-0-0-1 pattern then random
  task automatic drain(input int mode, output bit to);
    int k = 0;
    logic [3:0] pat = 4'b1001;
    while (obs_q.size() < exp_q.size() && k < 300) begin
      case (mode)
        0:       axi_rready = 1'b1;
        1:       axi_rready = 1'($urandom_range(0, 1));
        default: axi_rready = (k < 8) ? pat[k % 4] : 1'($urandom_range(0, 1));
      endcase
      @(posedge clk); #1;
      k++;
    end
    to = (obs_q.size() < exp_q.size());
    axi_rready = 1'b1;
    repeat (RD_LAT + 4) begin @(posedge clk); #1; end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({axi_arready, axi_rvalid, axi_rlast, axi_rresp, sram_ren} !== 6'b0) begin
      n_bad++;
      $display("FAIL reset_ctrl got arready=%b rvalid=%b rlast=%b rresp=%b ren=%b exp all 0",
               axi_arready, axi_rvalid, axi_rlast, axi_rresp, sram_ren);
    end
    n_cmp++;
    if (axi_rdata !== '0 || sram_raddr !== '0) begin
      n_bad++;
      $display("FAIL reset_data got rdata=%h raddr=%0d exp 0", axi_rdata, sram_raddr);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (axi_arready !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_arready_pre got %b exp 0", axi_arready);
    end
    @(negedge clk);
    n_cmp++;
    if (axi_arready !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_arready_post got %b exp 1", axi_arready);
    end
  endtask

  task automatic test_incr();
    int hs;
    bit to, to2;
    int exp_a[4] = '{2, 3, 4, 5};
    axi_rready = 1'b1;
    send_ar(64'h40, 3, OFS, 2'b01, hs, to);
    drain(0, to2);
    n_cmp++;
    if (to || to2 || obs_q.size() != 4 || addr_q.size() != 4) begin
      n_bad++;
      $display("FAIL incr_count got beats=%0d reads=%0d exp 4/4", obs_q.size(), addr_q.size());
    end
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (i >= addr_q.size() || addr_q[i] != exp_a[i] || addr_cyc_q[i] != hs + i) begin
        n_bad++;
        $display("FAIL incr_raddr%0d got %0d exp %0d at consecutive cycles", i,
                 (i < addr_q.size()) ? addr_q[i] : -1, exp_a[i]);
      end
      n_cmp++;
      if (i >= obs_q.size() || obs_q[i] !== exp_q[i] || obs_cyc_q[i] != hs + RD_LAT + 1 + i) begin
        n_bad++;
        $display("FAIL incr_beat%0d got %h cyc %0d exp %h cyc %0d", i,
                 (i < obs_q.size()) ? obs_q[i] : '0, (i < obs_cyc_q.size()) ? obs_cyc_q[i] : -1,
                 exp_q[i], hs + RD_LAT + 1 + i);
      end
    end
    @(negedge clk);
    n_cmp++;
    if (axi_arready !== 1'b1) begin
      n_bad++;
      $display("FAIL incr_idle got arready=%b exp 1", axi_arready);
    end
  endtask

  task automatic test_wrap();
    int hs;
    bit to, to2;
    int exp_a[4] = '{5, 6, 7, 4};
    axi_rready = 1'b1;
    send_ar(64'hA0, 3, OFS, 2'b10, hs, to);
    drain(0, to2);
    n_cmp++;
    if (to || to2 || obs_q.size() != 4 || addr_q.size() != 4) begin
      n_bad++;
      $display("FAIL wrap_count got beats=%0d reads=%0d exp 4/4", obs_q.size(), addr_q.size());
    end
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (i >= addr_q.size() || addr_q[i] != exp_a[i] ||
          i >= obs_q.size() || obs_q[i] !== exp_q[i]) begin
        n_bad++;
        $display("FAIL wrap_beat%0d got raddr %0d exp %0d", i,
                 (i < addr_q.size()) ? addr_q[i] : -1, exp_a[i]);
      end
    end
  endtask

  task automatic test_slverr();
    int hs;
    bit to, to2;
    axi_rready = 1'b1;
    send_ar(64'h10000, 1, OFS, 2'b01, hs, to);
    drain(0, to2);
    n_cmp++;
    if (addr_q.size() != 0) begin
      n_bad++;
      $display("FAIL slverr_ren got %0d reads exp 0", addr_q.size());
    end
    n_cmp++;
    if (to || to2 || obs_q.size() != 2) begin
      n_bad++;
      $display("FAIL slverr_count got %0d beats exp 2", obs_q.size());
    end
    for (int i = 0; i < 2; i++) begin
      n_cmp++;
      if (i >= obs_q.size() || obs_q[i] !== {{DATA_W{1'b0}}, 2'b10, (i == 1)}) begin
        n_bad++;
        $display("FAIL slverr_beat%0d got %h exp resp=2 rdata=0 last=%0d", i,
                 (i < obs_q.size()) ? obs_q[i] : '0, (i == 1));
      end
    end
  endtask

  task automatic test_stall();
    int hs;
    bit to, to2;
    axi_rready = 1'b1;
    send_ar(64'(300) << OFS, 15, OFS, 2'b01, hs, to);
    drain(2, to2);
    n_cmp++;
    if (to || to2 || obs_q.size() != 16) begin
      n_bad++;
      $display("FAIL stall_count got %0d beats exp 16", obs_q.size());
    end
    for (int i = 0; i < 16; i++) begin
      n_cmp++;
      if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) begin
        n_bad++;
        $display("FAIL stall_beat%0d got %h exp %h", i, (i < obs_q.size()) ? obs_q[i] : '0, exp_q[i]);
      end
    end
    n_cmp++;
    if (stall_viol != 0) begin
      n_bad++;
      $display("FAIL stall_stable got %0d unstable stall cycles exp 0", stall_viol);
    end
  endtask

  task automatic test_fixed();
    int hs;
    bit to, to2;
    axi_rready = 1'b1;
    send_ar(64'h20, 2, OFS, 2'b00, hs, to);
    drain(0, to2);
    n_cmp++;
    if (to || to2 || obs_q.size() != 3 || addr_q.size() != 3) begin
      n_bad++;
      $display("FAIL fixed_count got beats=%0d reads=%0d exp 3/3", obs_q.size(), addr_q.size());
    end
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (i >= addr_q.size() || addr_q[i] != 1 || i >= obs_q.size() ||
          obs_q[i] !== {mem[1], 2'b00, (i == 2)}) begin
        n_bad++;
        $display("FAIL fixed_beat%0d got raddr %0d exp 1", i, (i < addr_q.size()) ? addr_q[i] : -1);
      end
    end
  endtask

  task automatic test_reset_mid();
    int hs;
    bit to, to2;
    int k = 0;
    axi_rready = 1'b1;
    send_ar(64'(100) << OFS, 7, OFS, 2'b01, hs, to);
    while (obs_q.size() < 2 && k < 50) begin @(posedge clk); #1; k++; end
    n_cmp++;
    if (obs_q.size() != 2) begin
      n_bad++;
      $display("FAIL rstmid_reach got %0d beats before reset exp 2", obs_q.size());
    end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({axi_arready, axi_rvalid, axi_rlast, axi_rresp, sram_ren} !== 6'b0 ||
        axi_rdata !== '0 || sram_raddr !== '0) begin
      n_bad++;
      $display("FAIL rstmid_outputs got arready=%b rvalid=%b rlast=%b ren=%b raddr=%0d exp 0",
               axi_arready, axi_rvalid, axi_rlast, sram_ren, sram_raddr);
    end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    obs_q.delete(); obs_cyc_q.delete(); addr_q.delete(); addr_cyc_q.delete();
    repeat (20) begin @(posedge clk); #1; end
    n_cmp++;
    if (obs_q.size() != 0 || addr_q.size() != 0) begin
      n_bad++;
      $display("FAIL rstmid_quiet got %0d beats %0d reads after release exp 0/0",
               obs_q.size(), addr_q.size());
    end
    send_ar(64'(40) << OFS, 7, OFS, 2'b01, hs, to);
    drain(0, to2);
    n_cmp++;
    if (to || to2 || obs_q.size() != 8) begin
      n_bad++;
      $display("FAIL rstmid_next_count got %0d beats exp 8", obs_q.size());
    end
    for (int i = 0; i < 8; i++) begin
      n_cmp++;
      if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) begin
        n_bad++;
        $display("FAIL rstmid_next_beat%0d got %h exp %h", i, (i < obs_q.size()) ? obs_q[i] : '0, exp_q[i]);
      end
    end
  endtask

  task automatic test_random();
    for (int t = 0; t < 25; t++) begin
      int hs, len, size, idx, bad_beats, bad_addr;
      bit to, to2;
      logic [1:0] burst;
      logic [ADDR_W-1:0] addr;
      burst = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 9) < 8 && burst == 2'b11) burst = 2'b01;
      case (burst)
        2'b10:   len = ($urandom_range(0, 5) == 0) ? 2 : (2 << $urandom_range(0, 3)) - 1;
        default: len = $urandom_range(0, 15);
      endcase
      idx  = ($urandom_range(0, 5) == 0) ? DEPTH - $urandom_range(1, 8) : $urandom_range(0, DEPTH - 1);
      size = ($urandom_range(0, 9) == 0) ? 4 : OFS;
      addr = 64'(idx) << OFS;
      if ($urandom_range(0, 9) == 0) addr[OFS + SRAM_AW + $urandom_range(0, 20)] = 1'b1;
      axi_rready = 1'b1;
      send_ar(addr, len, size, burst, hs, to);
      drain(1, to2);
      bad_beats = 0;
      bad_addr = 0;
      for (int i = 0; i < exp_q.size(); i++)
        if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) bad_beats++;
      for (int i = 0; i < exp_idx_q.size(); i++)
        if (i >= addr_q.size() || addr_q[i] != exp_idx_q[i]) bad_addr++;
      n_cmp++;
      if (to || to2 || obs_q.size() != exp_q.size() || bad_beats != 0) begin
        n_bad++;
        $display("FAIL rand%0d_beats got %0d beats (%0d wrong) exp %0d addr=%h len=%0d burst=%0d",
                 t, obs_q.size(), bad_beats, exp_q.size(), addr, len, burst);
      end
      n_cmp++;
      if (addr_q.size() != exp_idx_q.size() || bad_addr != 0) begin
        n_bad++;
        $display("FAIL rand%0d_reads got %0d reads (%0d wrong) exp %0d", t, addr_q.size(),
                 bad_addr, exp_idx_q.size());
      end
      n_cmp++;
      if (stall_viol != 0) begin
        n_bad++;
        $display("FAIL rand%0d_stable got %0d unstable stall cycles exp 0", t, stall_viol);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++)
      for (int w = 0; w < DATA_W / 32; w++) mem[i][w*32 +: 32] = $urandom();
    test_reset();
    test_incr();
    test_wrap();
    test_slverr();
    test_stall();
    test_fixed();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pcie_axi_sram_rd_pipe.md
PCIE_AXI_SRAM_RD_PIPE -- requirements
Module: pcie_axi_sram_rd_pipe

Interface
REQ-001 SHALL have parameter DATA_W, default 256, data width in bits (power of 2, >=32).
REQ-002 SHALL have parameter ADDR_W, default 64, AXI address width.
REQ-003 SHALL have parameter SRAM_AW, default 10, SRAM word-address width.
REQ-004 SHALL have parameter LEN_W, default 12, arlen width.
REQ-005 SHALL have parameter RD_LAT, default 1, SRAM read latency in cycles (1..4).
REQ-006 SHALL have port clk, input, 1, clock; all logic on rising edge.
REQ-007 SHALL have port rst_n, input, 1, reset, asynchronous, active-low.
REQ-008 SHALL have ports axi_arvalid/axi_arready, input/output, 1 each, AR handshake.
REQ-009 SHALL have ports axi_araddr (ADDR_W), axi_arlen (LEN_W), axi_arsize (3), axi_arburst (2), inputs, AR payload.
REQ-010 SHALL have ports axi_rvalid/axi_rready, output/input, 1 each, R handshake.
REQ-011 SHALL have ports axi_rdata (DATA_W), axi_rresp (2), axi_rlast (1), outputs, R payload.
REQ-012 SHALL have ports sram_ren (1) and sram_raddr (SRAM_AW), outputs, and sram_rdata (DATA_W), input, valid RD_LAT cycles after sram_ren.

Function
REQ-013 SHALL define OFS = log2(DATA_W/8); SRAM word index = araddr[OFS+SRAM_AW-1:OFS].
REQ-014 SHALL implement states IDLE, BURST, DRAIN; arready=1 only in IDLE; one burst outstanding.
REQ-015 SHALL, on AR handshake, latch payload, beats = arlen+1 (LEN_W+1 bits, no overflow), go BURST.
REQ-016 SHALL flag SLVERR if araddr bits above OFS+SRAM_AW-1 are nonzero, arsize != OFS, arburst==2'b11, or burst end exceeds SRAM depth for INCR.
REQ-017 SHALL, for WRAP, require beats in {2,4,8,16} (else SLVERR) and wrap the word index within a beats-aligned window.
REQ-018 SHALL, for FIXED, reread the same word every beat; INCR increments the word index by 1.
REQ-019 SHALL, on SLVERR burst, issue no sram_ren and return beats beats with rdata=0, rresp=2'b10, rlast on final beat.
REQ-020 SHALL issue sram_ren in BURST every cycle that issued-minus-consumed < RD_LAT+2, until all beats issued, then go DRAIN.
REQ-021 SHALL capture returning sram_rdata into a RD_LAT+2 entry FIFO; R channel is the FIFO head.
REQ-022 SHALL sustain one beat per cycle with rready held high; first rvalid exactly RD_LAT+1 cycles after AR handshake.
REQ-023 SHALL keep rvalid, rdata, rresp, rlast stable while rvalid=1 and rready=0; no FIFO overflow under any rready pattern.
REQ-024 SHALL assert rlast only on beat beats-1; on rlast handshake go IDLE, arready=1 next cycle.
REQ-025 SHALL produce rresp=2'b00 for good bursts.

Reset
REQ-026 SHALL, on rst_n low at any time, force IDLE, arready=0 then 1 on first clock after release, rvalid=0, rlast=0, rresp=0, rdata=0, sram_ren=0, sram_raddr=0, FIFO empty, counters 0.
REQ-027 SHALL discard an in-flight burst on reset mid-operation; no R beat after release until a new AR.

Structure
REQ-028 SHALL place burst-type constants, resp constants, and state encoding in package pcie_axi_sram_pkg.
REQ-029 SHALL implement the read-data FIFO as sub-module pcie_axi_sram_rd_fifo (params DATA_W+3, DEPTH).
REQ-030 SHALL compute next word index in a single function in the package.

Verification
REQ-031 SHALL cover INCR araddr=0x40, arlen=3, rready=1 -> sram_raddr 2,3,4,5 on consecutive cycles, 4 back-to-back beats, rlast on 4th, rresp=0.
REQ-032 SHALL cover WRAP araddr=0xA0, arlen=3 -> word order 5,6,7,4.
REQ-033 SHALL cover araddr=0x10000 (DATA_W=256, SRAM_AW=10) arlen=1 -> no sram_ren, 2 beats rdata=0 rresp=2'b10.
REQ-034 SHALL cover INCR arlen=15 with rready toggling 1-0-0-1 random -> all 16 beats in order, data stable during stall, no loss.
REQ-035 SHALL cover FIXED araddr=0x20 arlen=2 -> sram_raddr=1 three times, 3 beats.
REQ-036 SHALL cover rst_n asserted mid-burst beat 2 of 8 -> outputs reset, no further beats, next AR served correctly.
